// File: rtl/adc_emul_pkg.sv
// Shared types and sizing helpers for the dual-channel SAR ADC responder model.
package adc_emul_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        SHIFT   = 2'd2
    } adc_state_e;

    localparam int unsigned DEFAULT_CHANNEL_DATA_WIDTH = 18;
    localparam int unsigned DEFAULT_FRAME_WIDTH        = 2 * DEFAULT_CHANNEL_DATA_WIDTH;

    function automatic int unsigned bit_cnt_width(input int unsigned frame_width);
        return (frame_width > 1) ? $clog2(frame_width) : 1;
    endfunction

    localparam int unsigned BIT_CNT_WIDTH = bit_cnt_width(DEFAULT_FRAME_WIDTH);

endpackage

// File: rtl/adc_emul_shifter.sv
// Frame shift register with bit counter; msb is the bit currently presented on MISO.
module adc_emul_shifter
    import adc_emul_pkg::*;
#(
    parameter int unsigned FRAME_WIDTH = DEFAULT_FRAME_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic                   shift,
    input  logic [FRAME_WIDTH-1:0] word,
    output logic                   msb,
    output logic                   last
);

    localparam int unsigned CNT_W = bit_cnt_width(FRAME_WIDTH);

    logic [FRAME_WIDTH-1:0] shift_reg_q;
    logic [CNT_W-1:0]       bit_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg_q <= '0;
            bit_cnt_q   <= '0;
        end else if (load) begin
            shift_reg_q <= word;
            bit_cnt_q   <= CNT_W'(FRAME_WIDTH - 1);
        end else if (shift && (bit_cnt_q != '0)) begin
            shift_reg_q <= {shift_reg_q[FRAME_WIDTH-2:0], 1'b0};
            bit_cnt_q   <= bit_cnt_q - CNT_W'(1);
        end
    end

    assign msb  = shift_reg_q[FRAME_WIDTH-1];
    assign last = (bit_cnt_q == '0);

endmodule

// File: rtl/adc_spi_emulator.sv
// Responder model of the dual-channel SAR ADC: CNV -> BUSY for CONV_CYCLES -> MSB-first frame on
// MISO, advanced by falling SCK edges from a master sharing clk.
module adc_spi_emulator
    import adc_emul_pkg::*;
#(
    parameter int unsigned CHANNEL_DATA_WIDTH = DEFAULT_CHANNEL_DATA_WIDTH,
    parameter int unsigned FRAME_WIDTH        = 2 * CHANNEL_DATA_WIDTH,
    parameter int unsigned CONV_CYCLES        = 5,
    parameter int unsigned RAMP_STEP          = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cnv,
    input  logic                          sck,
    output logic                          miso,
    output logic                          busy,
    input  logic [CHANNEL_DATA_WIDTH-1:0] ch1_value,
    input  logic [CHANNEL_DATA_WIDTH-1:0] ch2_value,
    input  logic                          ramp_en,
    output logic                          frame_done,
    output logic                          overrun,
    input  logic                          overrun_clr
);

    adc_state_e                    state_q, state_d;
    logic [7:0]                    conv_cnt_q, conv_cnt_d;
    logic [CHANNEL_DATA_WIDTH-1:0] ramp_q, ramp_d;
    logic                          busy_q, busy_d;
    logic                          overrun_q, overrun_d;
    logic                          frame_done_q, frame_done_d;
    logic                          cnv_prev_q, sck_prev_q;

    logic                   cnv_rise, sck_fall;
    logic                   accept, overrun_set, load, shift, msb, last;
    logic [FRAME_WIDTH-1:0] word;

    // SCK and CNV come from the same clk domain, so one history flop is enough.
    assign cnv_rise = cnv & ~cnv_prev_q;
    assign sck_fall = ~sck & sck_prev_q;

    always_comb begin
        word = ramp_en ? {~ramp_q, ramp_q} : {ch2_value, ch1_value};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            conv_cnt_q   <= '0;
            ramp_q       <= '0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
            frame_done_q <= 1'b0;
            cnv_prev_q   <= cnv;
            sck_prev_q   <= sck;
        end else begin
            state_q      <= state_d;
            conv_cnt_q   <= conv_cnt_d;
            ramp_q       <= ramp_d;
            busy_q       <= busy_d;
            overrun_q    <= overrun_d;
            frame_done_q <= frame_done_d;
            cnv_prev_q   <= cnv;
            sck_prev_q   <= sck;
        end
    end

    always_comb begin
        state_d      = state_q;
        conv_cnt_d   = conv_cnt_q;
        ramp_d       = ramp_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        accept       = 1'b0;
        overrun_set  = 1'b0;
        shift        = 1'b0;

        unique case (state_q)
            IDLE: begin
                accept = cnv_rise;
            end
            CONVERT: begin
                overrun_set = cnv_rise;
                if (conv_cnt_q == 8'd0) begin
                    busy_d  = 1'b0;
                    state_d = SHIFT;
                end else begin
                    conv_cnt_d = conv_cnt_q - 8'd1;
                end
            end
            SHIFT: begin
                // A new CNV aborts the frame in flight and restarts exactly as from IDLE.
                if (cnv_rise) begin
                    accept      = 1'b1;
                    overrun_set = 1'b1;
                end else if (sck_fall) begin
                    if (last) begin
                        frame_done_d = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        shift = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (accept) begin
            state_d    = CONVERT;
            busy_d     = 1'b1;
            conv_cnt_d = 8'(CONV_CYCLES - 1);
            if (ramp_en) begin
                ramp_d = ramp_q + CHANNEL_DATA_WIDTH'(RAMP_STEP);
            end
        end

        // Set wins over a simultaneous clear.
        overrun_d = overrun_set | (overrun_q & ~overrun_clr);
    end

    assign load = accept;

    adc_emul_shifter #(
        .FRAME_WIDTH(FRAME_WIDTH)
    ) u_shifter (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .shift(shift),
        .word (word),
        .msb  (msb),
        .last (last)
    );

    assign miso       = (state_q == SHIFT) & msb;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_adc_spi_emulator.sv
// Directed bench for adc_spi_emulator: frame-level queue model checked every cycle plus literal
// expectations on received words, BUSY length and frame_done counts.
module tb_adc_spi_emulator;

    localparam int unsigned CW   = 18;
    localparam int unsigned FW   = 36;
    localparam int unsigned CONV = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cnv = 1'b0;
    logic          sck = 1'b0;
    logic          miso, busy, frame_done, overrun;
    logic [CW-1:0] ch1_value = '0;
    logic [CW-1:0] ch2_value = '0;
    logic          ramp_en = 1'b0;
    logic          overrun_clr = 1'b0;

    adc_spi_emulator #(
        .CHANNEL_DATA_WIDTH(CW),
        .FRAME_WIDTH       (FW),
        .CONV_CYCLES       (CONV),
        .RAMP_STEP         (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cnv        (cnv),
        .sck        (sck),
        .miso       (miso),
        .busy       (busy),
        .ch1_value  (ch1_value),
        .ch2_value  (ch2_value),
        .ramp_en    (ramp_en),
        .frame_done (frame_done),
        .overrun    (overrun),
        .overrun_clr(overrun_clr)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Frame-level model: remaining BUSY cycles, queue of bits still to be presented.
    int            m_busy_left = 0;
    bit            m_bits[$];
    bit            m_in_frame = 0;
    int            m_ramp = 0;
    bit            m_overrun = 0;
    bit            m_done = 0;
    bit            m_pcnv = 0;
    bit            m_psck = 0;

    int            busy_run = 0;
    int            busy_len = 0;
    int            done_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_accept();
        logic [CW-1:0] c1, c2;
        logic [FW-1:0] w;
        if (ramp_en) begin
            c1 = CW'(m_ramp);
            c2 = ~c1;
            m_ramp = (m_ramp + 1) % (1 << CW);
        end else begin
            c1 = ch1_value;
            c2 = ch2_value;
        end
        w = {c2, c1};
        m_bits.delete();
        for (int i = FW - 1; i >= 0; i--) m_bits.push_back(w[i]);
        m_busy_left = CONV;
        m_in_frame  = 0;
    endtask

    task automatic model_loop();
        bit rise, fall, set;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_busy_left = 0;
                m_bits.delete();
                m_in_frame = 0;
                m_ramp     = 0;
                m_overrun  = 0;
                m_done     = 0;
            end else begin
                rise   = cnv && !m_pcnv;
                fall   = !sck && m_psck;
                set    = 0;
                m_done = 0;
                if (m_busy_left > 0) begin
                    if (rise) set = 1;
                    m_busy_left--;
                    if (m_busy_left == 0) m_in_frame = 1;
                end else if (m_in_frame) begin
                    if (rise) begin
                        set = 1;
                        model_accept();
                    end else if (fall) begin
                        void'(m_bits.pop_front());
                        if (m_bits.size() == 0) begin
                            m_in_frame = 0;
                            m_done     = 1;
                        end
                    end
                end else if (rise) begin
                    model_accept();
                end
                if (set) m_overrun = 1;
                else if (overrun_clr) m_overrun = 0;
            end
            m_pcnv = cnv;
            m_psck = sck;
        end
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            check("busy", busy, (m_busy_left > 0));
            check("miso", miso, (m_in_frame && m_bits.size() > 0) ? m_bits[0] : 1'b0);
            check("frame_done", frame_done, m_done);
            check("overrun", overrun, m_overrun);
            if (busy === 1'b1) busy_run++;
            else if (busy_run > 0) begin
                busy_len = busy_run;
                busy_run = 0;
            end
            if (frame_done === 1'b1) done_cnt++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_cnv();
        cnv = 1'b1;
        tick();
        cnv = 1'b0;
        tick();
    endtask

    task automatic wait_busy_low();
        int k = 0;
        while (busy === 1'b1 && k < 50) begin
            tick();
            k++;
        end
        check("busy_timeout", (k < 50), 1);
    endtask

    task automatic read_bits(input int n, output logic [FW-1:0] w);
        w = '0;
        for (int i = 0; i < n; i++) begin
            sck = 1'b1;
            w   = {w[FW-2:0], miso};
            tick();
            tick();
            sck = 1'b0;
            tick();
            tick();
        end
    endtask

    task automatic clear_overrun();
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        tick();
    endtask

    initial begin
        logic [FW-1:0] w;
        int            base;

        fork
            model_loop();
            compare_loop();
        join_none

        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_miso", miso, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_overrun", overrun, 0);
        rst = 1'b0;
        tick();

        // Basic frame
        base      = done_cnt;
        ch1_value = 18'h00001;
        ch2_value = 18'h3FFFF;
        pulse_cnv();
        wait_busy_low();
        read_bits(FW, w);
        check("basic_word", w, 36'hFFFFC0001);
        check("basic_busy_len", busy_len, CONV);
        check("basic_done_cnt", done_cnt - base, 1);
        check("basic_miso_after", miso, 0);

        // Ramp: three consecutive conversions
        ramp_en = 1'b1;
        pulse_cnv();
        wait_busy_low();
        read_bits(FW, w);
        check("ramp0_word", w, 36'hFFFFC0000);
        pulse_cnv();
        wait_busy_low();
        read_bits(FW, w);
        check("ramp1_word", w, 36'hFFFF80001);
        pulse_cnv();
        wait_busy_low();
        read_bits(FW, w);
        check("ramp2_word", w, 36'hFFFF40002);
        ramp_en = 1'b0;

        // Overrun during CONVERT
        ch1_value = 18'h12345;
        ch2_value = 18'h2ABCD;
        cnv = 1'b1;
        tick();
        cnv = 1'b0;
        tick();
        cnv = 1'b1;
        tick();
        cnv = 1'b0;
        ch1_value = 18'h00000;
        ch2_value = 18'h11111;
        tick();
        wait_busy_low();
        check("ovr_conv_flag", overrun, 1);
        read_bits(FW, w);
        check("ovr_conv_word", w, 36'hAAF352345);
        check("ovr_conv_busy_len", busy_len, CONV);
        clear_overrun();
        check("ovr_conv_cleared", overrun, 0);

        // Abort during SHIFT after 10 bits
        base      = done_cnt;
        ch1_value = 18'h15555;
        ch2_value = 18'h2AAAA;
        pulse_cnv();
        wait_busy_low();
        read_bits(10, w);
        ch1_value = 18'h00F0F;
        ch2_value = 18'h3C3C3;
        cnv = 1'b1;
        tick();
        check("abort_busy_rise", busy, 1);
        cnv = 1'b0;
        tick();
        wait_busy_low();
        read_bits(FW, w);
        check("abort_word", w, 36'hF0F0C0F0F);
        check("abort_overrun", overrun, 1);
        check("abort_done_cnt", done_cnt - base, 1);
        clear_overrun();

        // Reset mid-frame after 20 bits
        ramp_en   = 1'b1;
        pulse_cnv();
        ramp_en   = 1'b0;
        wait_busy_low();
        read_bits(20, w);
        rst = 1'b1;
        tick();
        check("midrst_busy", busy, 0);
        check("midrst_miso", miso, 0);
        check("midrst_frame_done", frame_done, 0);
        rst = 1'b0;
        tick();
        base      = done_cnt;
        ch1_value = 18'h0000A;
        ch2_value = 18'h20000;
        pulse_cnv();
        wait_busy_low();
        read_bits(FW, w);
        check("postrst_word", w, 36'h80000000A);
        check("postrst_done_cnt", done_cnt - base, 1);
        ramp_en = 1'b1;
        pulse_cnv();
        ramp_en = 1'b0;
        wait_busy_low();
        read_bits(FW, w);
        check("postrst_ramp_word", w, 36'hFFFFC0000);

        // Stray SCK in IDLE
        for (int i = 0; i < 8; i++) begin
            sck = 1'b1;
            tick();
            check("stray_miso_hi", miso, 0);
            sck = 1'b0;
            tick();
            check("stray_miso_lo", miso, 0);
        end
        base      = done_cnt;
        ch1_value = 18'h00001;
        ch2_value = 18'h20000;
        pulse_cnv();
        wait_busy_low();
        check("stray_first_bit", miso, 1);
        read_bits(FW, w);
        check("stray_word", w, 36'h800000001);
        check("stray_done_cnt", done_cnt - base, 1);

        tick();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/adc_spi_emulator.md
Name: adc_spi_emulator

Overview:
- Synthesizable responder model of the dual-channel SAR ADC that the acquisition front end reads: detects CNV, asserts BUSY for a programmable conversion time, then shifts a 2×CHANNEL_DATA_WIDTH word out on MISO, clocked by the SPI master's SCK.
- Used in loopback builds and benches in place of the physical ADC.
- Shares clk with the SPI master. SCK and CNV are generated in the same clock domain, so they are edge-detected with a single history register and are not synchronized.

Parameters:
- CHANNEL_DATA_WIDTH, 18, bits per channel.
- FRAME_WIDTH, 2*CHANNEL_DATA_WIDTH, shifted word length.
- CONV_CYCLES, 5, clk cycles BUSY stays high per conversion (valid range 1..255).
- RAMP_STEP, 1, increment applied to the internal ramp per conversion.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- cnv  in  1  conversion start; rising edge triggers.
- sck  in  1  SPI clock from master, idle low; slave shifts on falling edge, master samples on rising edge.
- miso  out  1  serial data, MSB first.
- busy  out  1  high during conversion.
- ch1_value  in  CHANNEL_DATA_WIDTH  external channel-1 sample.
- ch2_value  in  CHANNEL_DATA_WIDTH  external channel-2 sample.
- ramp_en  in  1  1 = use internal ramp instead of ch1_value/ch2_value.
- frame_done  out  1  one-cycle pulse after the last bit is shifted out.
- overrun  out  1  sticky error flag.
- overrun_clr  in  1  clears overrun.

Behaviour:
- Reset values: miso=0, busy=0, frame_done=0, overrun=0, ramp=0, shift_reg=0, state=IDLE. Edge history registers are loaded with the current cnv and sck, so no false edge appears after reset.
- Edge detect: cnv_rise = cnv & ~cnv_prev; sck_fall = ~sck & sck_prev.
- State IDLE: on cnv_rise, latch the word and go to CONVERT.
  - Word = {ch2, ch1}; ch2 occupies the upper CHANNEL_DATA_WIDTH bits.
  - ch1 = ramp_en ? ramp : ch1_value.
  - ch2 = ramp_en ? ~ramp : ch2_value.
  - ramp += RAMP_STEP (mod 2^CHANNEL_DATA_WIDTH), only when ramp_en=1.
  - Load conv_cnt = CONV_CYCLES-1. busy goes high the cycle after the cnv edge is registered.
- State CONVERT:
  - busy=1. conv_cnt decrements each cycle.
  - When conv_cnt==0: busy<=0, miso<=word[FRAME_WIDTH-1], bit_cnt<=FRAME_WIDTH-1, go to SHIFT.
  - BUSY is high for exactly CONV_CYCLES cycles.
  - sck edges are ignored in this state.
- State SHIFT:
  - On each sck_fall with bit_cnt>0: shift left, miso<=next bit, bit_cnt--.
  - On sck_fall with bit_cnt==0: miso<=0, frame_done=1 for one cycle, go to IDLE.
  - The master samples FRAME_WIDTH rising edges. The falling edge after the last rising edge terminates the frame.
- cnv_rise during CONVERT: ignored; overrun<=1; conversion continues.
- cnv_rise during SHIFT:
  - The current frame is aborted and a new conversion starts, exactly as from IDLE.
  - overrun<=1; no frame_done pulse.
- overrun stays high until overrun_clr. If overrun_clr and a new overrun event occur in the same cycle, the set wins.
- sck activity in IDLE has no effect; miso stays 0.
- ch1_value, ch2_value and ramp_en are sampled only on the accepted cnv edge; later changes do not affect the frame in flight.
- Reset mid-conversion or mid-shift returns to IDLE immediately. busy and miso are 0 on the next cycle, and the ramp restarts at 0.

Decomposition:
- Shared package adc_emul_pkg:
  - state encoding: IDLE, CONVERT, SHIFT (2 bits);
  - default CHANNEL_DATA_WIDTH;
  - helper constant for the bit_cnt width, $clog2(FRAME_WIDTH).
- One natural sub-module: adc_emul_shifter. It holds the FRAME_WIDTH load/shift register, the bit counter and the last-bit flag, and exposes load, shift, msb and last. The FSM, conversion counter, ramp and overrun logic stay in the top.

Test Plan:
- Basic frame: after reset, ch1=18'h00001, ch2=18'h3FFFF, one cnv pulse, master clocks 36 bits -> busy high for exactly 5 clks; received word = 36'hFFFFC0001; one frame_done pulse on the 36th sck falling edge; miso=0 afterwards.
- Ramp: ramp_en=1, 3 consecutive conversions -> ch1 words 0, 1, 2 and ch2 words 3FFFF, 3FFFE, 3FFFD.
- Overrun in CONVERT: second cnv rise 2 clks after the first -> busy length unchanged at 5; overrun=1; the frame still carries the first-latched values. After overrun_clr, overrun=0.
- Abort in SHIFT: cnv rise after 10 bits have shifted -> no frame_done; busy rises the next cycle; new frame with new values; overrun=1.
- Reset mid-frame: rst asserted after 20 bits -> the next cycle has busy=0, miso=0, state IDLE; the next cnv produces a clean full frame.
- Stray sck: 8 sck pulses in IDLE, then a normal conversion -> miso=0 during the pulses; the following frame is intact and MSB-first.
